// File: rtl/la_prog_pkg.sv
// Shared opcodes, FSM states and LA word field positions for the LA programming bridge.
package la_prog_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_SETA  = 3'd1;
    localparam logic [2:0] OP_PUSH  = 3'd2;
    localparam logic [2:0] OP_WRITE = 3'd3;
    localparam logic [2:0] OP_READ  = 3'd4;
    localparam logic [2:0] OP_HSEL  = 3'd5;
    localparam logic [2:0] OP_HALT  = 3'd6;
    localparam logic [2:0] OP_RUN   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RDW  = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam int CMD_REQ_BIT    = 31;
    localparam int CMD_OP_LSB     = 28;
    localparam int CMD_OP_W       = 3;
    localparam int CMD_PAY_W      = 16;

    localparam int STAT_ACK_BIT   = 31;
    localparam int STAT_HALT_BIT  = 30;
    localparam int STAT_ERR_BIT   = 29;
    localparam int STAT_ADDR_LSB  = 16;
    localparam int STAT_ADDR_W    = 13;

    localparam int HALF_W         = 16;

endpackage

// File: rtl/la_prog_bridge.sv
// Toggle-handshake command bridge from the Caravel LA bus to the core's memory and reset.
// The host flips REQ to post a command; the bridge echoes it on ACK once the command completes.
module la_prog_bridge
    import la_prog_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter bit BOOT_HALTED = 1'b1
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic              active,
    input  logic [31:0]       la1_data_in,
    input  logic [31:0]       la1_oenb,
    output logic [31:0]       la1_data_out,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_rst_n,
    output logic              busy
);

    localparam int         BEATS   = DATA_W / HALF_W;
    localparam logic [2:0] BEATS_C = 3'(BEATS);

    state_t                 state;
    state_t                 state_nxt;
    logic                   req_q;
    logic                   ack_q;
    logic                   err_q;
    logic                   core_run_q;
    logic [CMD_OP_W-1:0]    op_q;
    logic [CMD_PAY_W-1:0]   pay_q;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      wbuf;
    logic [DATA_W-1:0]      rbuf;
    logic [1:0]             hsel;
    logic [2:0]             beat_cnt;
    logic                   mem_we_q;
    logic                   mem_re_q;

    logic                   halted;
    logic                   req_in;
    logic                   accept;
    logic [CMD_OP_W-1:0]    cmd_op;
    logic [DATA_W+15:0]     push_word;
    logic [HALF_W-1:0]      rd_half;
    logic                   unused_ok;

    assign halted    = !core_run_q;
    assign req_in    = la1_data_in[CMD_REQ_BIT];
    assign cmd_op    = la1_data_in[CMD_OP_LSB +: CMD_OP_W];
    assign push_word = {wbuf, pay_q};
    assign accept    = (state == IDLE) && active && !la1_oenb[CMD_REQ_BIT] && (req_in != req_q);
    assign unused_ok = &{1'b0, la1_oenb[30:0], la1_data_in[27:16]};

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!active) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = EXEC;
                EXEC:    state_nxt = (op_q == OP_READ && halted) ? RDW : ACK;
                RDW:     state_nxt = ACK;
                ACK:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Strobes are registered at acceptance so they are clean for the whole EXEC cycle.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            core_run_q <= !BOOT_HALTED;
            op_q       <= OP_NOP;
            pay_q      <= '0;
            addr       <= '0;
            wbuf       <= '0;
            rbuf       <= '0;
            hsel       <= 2'd0;
            beat_cnt   <= 3'd0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            if (!active) begin
                req_q <= req_in;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            req_q    <= req_in;
                            op_q     <= cmd_op;
                            pay_q    <= la1_data_in[CMD_PAY_W-1:0];
                            mem_we_q <= (cmd_op == OP_WRITE) && halted;
                            mem_re_q <= (cmd_op == OP_READ) && halted;
                        end
                    end
                    EXEC: begin
                        case (op_q)
                            OP_NOP: err_q <= 1'b0;
                            OP_SETA: begin
                                addr     <= pay_q[ADDR_W-1:0];
                                beat_cnt <= 3'd0;
                            end
                            OP_PUSH: begin
                                wbuf <= push_word[DATA_W-1:0];
                                if (beat_cnt != BEATS_C) beat_cnt <= beat_cnt + 3'd1;
                            end
                            OP_WRITE: begin
                                if (halted) begin
                                    addr     <= addr + ADDR_W'(1);
                                    beat_cnt <= 3'd0;
                                    if (beat_cnt != BEATS_C) err_q <= 1'b1;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            OP_READ: begin
                                if (halted) begin
                                    addr <= addr + ADDR_W'(1);
                                    hsel <= 2'd0;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            OP_HSEL: hsel <= ({1'b0, pay_q[1:0]} < BEATS_C) ? pay_q[1:0] : 2'd0;
                            OP_HALT: core_run_q <= 1'b0;
                            OP_RUN:  core_run_q <= 1'b1;
                            default: ;
                        endcase
                    end
                    RDW:     rbuf  <= mem_rdata;
                    ACK:     ack_q <= req_q;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_half = rbuf[HALF_W-1:0];
        for (int i = 1; i < BEATS; i++) begin
            if (hsel == 2'(i)) rd_half = rbuf[i*HALF_W +: HALF_W];
        end
    end

    assign la1_data_out = {ack_q, halted, err_q, STAT_ADDR_W'(addr), rd_half};
    assign mem_we       = mem_we_q & active;
    assign mem_re       = mem_re_q & active;
    assign mem_addr     = addr;
    assign mem_wdata    = wbuf;
    assign core_rst_n   = core_run_q;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_la_prog_bridge.sv
// Directed test-plan steps plus a randomized command stream, each checked against a
// command-level reference model of the bridge and a small memory model.
module tb_la_prog_bridge;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BEATS  = DATA_W / 16;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [2:0] T_NOP = 3'd0, T_SETA = 3'd1, T_PUSH = 3'd2, T_WRITE = 3'd3;
    localparam logic [2:0] T_READ = 3'd4, T_HSEL = 3'd5, T_HALT = 3'd6, T_RUN = 3'd7;

    logic              wb_clk_i = 1'b0;
    logic              rst_n;
    logic              active;
    logic [31:0]       la1_data_in;
    logic [31:0]       la1_oenb;
    logic [31:0]       la1_data_out;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              core_rst_n;
    logic              busy;

    la_prog_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BOOT_HALTED(1'b1)) dut (
        .wb_clk_i    (wb_clk_i),
        .rst_n       (rst_n),
        .active      (active),
        .la1_data_in (la1_data_in),
        .la1_oenb    (la1_oenb),
        .la1_data_out(la1_data_out),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .core_rst_n  (core_rst_n),
        .busy        (busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Synchronous memory: read data appears the cycle after mem_re, garbage otherwise.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge wb_clk_i) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_re ? mem[mem_addr] : DATA_W'($urandom);
    end

    int                we_cnt = 0;
    int                re_cnt = 0;
    logic [ADDR_W-1:0] we_addr;
    logic [DATA_W-1:0] we_data;
    always @(negedge wb_clk_i) begin
        if (mem_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = mem_addr;
            we_data = mem_wdata;
        end
        if (mem_re) re_cnt = re_cnt + 1;
    end

    // Reference model state, kept at the level of the command semantics.
    int                m_addr;
    logic [15:0]       m_beats_q[$];
    int                m_beat_cnt;
    bit                m_halted;
    bit                m_err;
    logic [DATA_W-1:0] m_rbuf;
    int                m_hsel;
    bit                m_ack;
    logic [DATA_W-1:0] m_mem[int];

    bit                cur_req;
    int                errors = 0;
    int                checks = 0;
    int                obs_lat;
    int                exp_lat;
    int                exp_we;
    int                exp_re;
    int                we_base;
    int                re_base;
    logic [ADDR_W-1:0] exp_waddr;
    logic [DATA_W-1:0] exp_wdata;
    bit                busy_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_word();
        logic [DATA_W-1:0] w = '0;
        foreach (m_beats_q[i]) w = (w << 16) | DATA_W'(m_beats_q[i]);
        return w;
    endfunction

    function automatic logic [31:0] model_out();
        logic [15:0] half = 16'(m_rbuf >> (16 * m_hsel));
        return {m_ack, m_halted, m_err, 13'(m_addr), half};
    endfunction

    task automatic model_reset();
        m_addr     = 0;
        m_beats_q.delete();
        m_beat_cnt = 0;
        m_halted   = 1'b1;
        m_err      = 1'b0;
        m_rbuf     = '0;
        m_hsel     = 0;
        m_ack      = 1'b0;
    endtask

    task automatic model_exec(input logic [2:0] op, input logic [15:0] pay);
        exp_we  = 0;
        exp_re  = 0;
        exp_lat = 3;
        case (op)
            T_NOP:  m_err = 1'b0;
            T_SETA: begin
                m_addr     = int'(pay) % DEPTH;
                m_beat_cnt = 0;
            end
            T_PUSH: begin
                m_beats_q.push_back(pay);
                if (m_beats_q.size() > BEATS) void'(m_beats_q.pop_front());
                if (m_beat_cnt < BEATS) m_beat_cnt++;
            end
            T_WRITE: begin
                if (m_halted) begin
                    exp_we         = 1;
                    exp_waddr      = ADDR_W'(m_addr);
                    exp_wdata      = model_word();
                    m_mem[m_addr]  = exp_wdata;
                    if (m_beat_cnt != BEATS) m_err = 1'b1;
                    m_addr         = (m_addr + 1) % DEPTH;
                    m_beat_cnt     = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
            T_READ: begin
                if (m_halted) begin
                    exp_re  = 1;
                    exp_lat = 4;
                    m_rbuf  = m_mem.exists(m_addr) ? m_mem[m_addr] : '0;
                    m_addr  = (m_addr + 1) % DEPTH;
                    m_hsel  = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
            T_HSEL: m_hsel = ((int'(pay) % 4) < BEATS) ? int'(pay) % 4 : 0;
            T_HALT: m_halted = 1'b1;
            default: m_halted = 1'b0;
        endcase
    endtask

    task automatic do_reset();
        active      = 1'b1;
        la1_oenb    = 32'h0;
        la1_data_in = 32'h0;
        cur_req     = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Posts one command and waits, bounded, for the handshake to complete.
    task automatic apply_stimulus(input logic [2:0] op, input logic [15:0] pay, input bit double_toggle = 1'b0);
        @(negedge wb_clk_i);
        we_base = we_cnt;
        re_base = re_cnt;
        model_exec(op, pay);
        cur_req     = ~cur_req;
        m_ack       = cur_req;
        la1_data_in = {cur_req, op, 12'h000, pay};
        obs_lat     = 0;
        do begin
            @(negedge wb_clk_i);
            obs_lat++;
            if (double_toggle && obs_lat == 1) la1_data_in[31] = ~cur_req;
            if (double_toggle && obs_lat == 2) la1_data_in[31] = cur_req;
        end while (!(la1_data_out[31] === cur_req && busy === 1'b0) && obs_lat < 20);
    endtask

    task automatic check_output(input string tag);
        check({tag, ".lat"}, obs_lat, exp_lat);
        check({tag, ".out"}, la1_data_out, model_out());
        check({tag, ".busy"}, busy, 0);
        check({tag, ".core_rst_n"}, core_rst_n, !m_halted);
        check({tag, ".we_cnt"}, we_cnt - we_base, exp_we);
        check({tag, ".re_cnt"}, re_cnt - re_base, exp_re);
        if (exp_we != 0) begin
            check({tag, ".waddr"}, we_addr, exp_waddr);
            check({tag, ".wdata"}, we_data, exp_wdata);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [15:0] pay, input string tag);
        apply_stimulus(op, pay);
        check_output(tag);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rst_n = 1'b0;
        do_reset();

        // Reset state with the core booting halted
        @(negedge wb_clk_i);
        check("rst.core_rst_n", core_rst_n, 0);
        check("rst.out", la1_data_out, 32'h4000_0000);
        check("rst.busy", busy, 0);
        check("rst.we", mem_we, 0);

        // Assemble and write one word
        run_cmd(T_SETA, 16'h0005, "t2.seta");
        run_cmd(T_PUSH, 16'hDEAD, "t2.push0");
        run_cmd(T_PUSH, 16'hBEEF, "t2.push1");
        run_cmd(T_WRITE, 16'h0000, "t2.write");
        check("t2.wdata_const", we_data, 32'hDEADBEEF);
        check("t2.waddr_const", we_addr, 5);
        check("t2.addr_field", la1_data_out[28:16], 6);
        check("t2.err", la1_data_out[29], 0);

        // Read it back and select each half
        run_cmd(T_SETA, 16'h0005, "t3.seta");
        run_cmd(T_READ, 16'h0000, "t3.read");
        check("t3.half0", la1_data_out[15:0], 16'hBEEF);
        run_cmd(T_HSEL, 16'h0001, "t3.hsel1");
        check("t3.half1", la1_data_out[15:0], 16'hDEAD);
        run_cmd(T_HSEL, 16'h0003, "t3.hsel_oor");

        // Memory access while running is refused and flagged
        run_cmd(T_RUN, 16'h0000, "t4.run");
        run_cmd(T_WRITE, 16'h0000, "t4.write");
        check("t4.err", la1_data_out[29], 1);
        run_cmd(T_READ, 16'h0000, "t4.read");
        run_cmd(T_NOP, 16'h0000, "t4.nop");
        check("t4.err_clr", la1_data_out[29], 0);
        run_cmd(T_HALT, 16'h0000, "t4.halt");

        // Address wrap and incomplete-word write
        run_cmd(T_SETA, 16'h03FF, "t5.seta");
        run_cmd(T_PUSH, 16'h1234, "t5.push0");
        run_cmd(T_PUSH, 16'h5678, "t5.push1");
        run_cmd(T_WRITE, 16'h0000, "t5.write");
        check("t5.waddr_const", we_addr, 10'h3FF);
        check("t5.addr_wrap", la1_data_out[28:16], 0);
        run_cmd(T_PUSH, 16'h9ABC, "t5.push2");
        run_cmd(T_WRITE, 16'h0000, "t5.short");
        check("t5.short_err", la1_data_out[29], 1);

        // Two REQ toggles during one busy period cancel out
        apply_stimulus(T_SETA, 16'h0010, 1'b1);
        check_output("t6.dbl");
        busy_seen = 1'b0;
        repeat (4) begin
            @(negedge wb_clk_i);
            busy_seen |= busy;
        end
        check("t6.dbl_busy", busy_seen, 0);

        // A toggle while inactive is dropped
        @(negedge wb_clk_i);
        we_base     = we_cnt;
        active      = 1'b0;
        cur_req     = ~cur_req;
        la1_data_in = {cur_req, T_WRITE, 28'h0};
        busy_seen   = 1'b0;
        repeat (3) begin
            @(negedge wb_clk_i);
            busy_seen |= busy;
        end
        active = 1'b1;
        repeat (4) begin
            @(negedge wb_clk_i);
            busy_seen |= busy;
        end
        check("t6.inact_busy", busy_seen, 0);
        check("t6.inact_we", we_cnt - we_base, 0);
        check("t6.inact_out", la1_data_out, model_out());
        run_cmd(T_SETA, 16'h0005, "t6.resume");

        // Reset asserted while waiting for read data aborts the command
        do_reset();
        run_cmd(T_SETA, 16'h0005, "t6.rst_seta");
        run_cmd(T_NOP, 16'h0000, "t6.rst_nop");
        @(negedge wb_clk_i);
        we_base     = we_cnt;
        cur_req     = ~cur_req;
        la1_data_in = {cur_req, T_READ, 28'h0};
        repeat (2) @(negedge wb_clk_i);
        #2 rst_n = 1'b0;
        #1;
        check("t6.abort_busy", busy, 0);
        check("t6.abort_out", la1_data_out, 32'h4000_0000);
        check("t6.abort_re", mem_re, 0);
        la1_data_in = 32'h0;
        cur_req     = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge wb_clk_i);
        check("t6.abort_noack", la1_data_out, 32'h4000_0000);
        check("t6.abort_we", we_cnt - we_base, 0);

        // Randomized command stream
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  op;
            logic [15:0] pay;
            op  = 3'($urandom_range(0, 7));
            pay = 16'($urandom);
            if (op == T_RUN && $urandom_range(0, 2) != 0) op = T_HALT;
            if (op == T_SETA && $urandom_range(0, 3) == 0) pay = 16'(DEPTH - 1);
            run_cmd(op, pay, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/la_prog_bridge.md
# la_prog_bridge

Parametrised logic-analyzer programming and debug bridge for the RV32I user-project macro. It is clocked by `wb_clk_i` and sits between the Caravel LA bus and the core's instruction/data memory and core reset. The management CPU issues 16-bit-beat commands through the LA bus using a toggle handshake: halt or run the core, set an address, assemble words, write them, and read them back. This lets firmware be loaded and inspected without the wishbone port.

## Interface
Parameters:
- `ADDR_W`, default 10: memory word-address width; legal range 1..13.
- `DATA_W`, default 32: memory word width; must be a multiple of 16, legal range 16..64.
- `BOOT_HALTED`, default 1: if 1, the core is held in reset after bridge reset.

Ports:
- `wb_clk_i`  in  1: the only clock.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `active`  in  1: project-select; the bridge ignores the LA bus while this is low.
- `la1_data_in`  in  32: command word from the CPU.
- `la1_oenb`  in  32: LA output-enable-bar; a bit is valid only when it is 0.
- `la1_data_out`  out  32: status and read data to the CPU.
- `mem_we`  out  1: single-cycle write strobe.
- `mem_re`  out  1: single-cycle read strobe.
- `mem_addr`  out  ADDR_W: memory word address.
- `mem_wdata`  out  DATA_W: write data.
- `mem_rdata`  in  DATA_W: read data, valid the cycle after `mem_re`.
- `core_rst_n`  out  1: core reset, active-low.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
Command word layout:
- [31] REQ toggle.
- [30:28] OP.
- [27:16] ignored.
- [15:0] PAY.

Command acceptance:
- A command is accepted in IDLE when `active`=1, `la1_oenb[31]`=0, and `la1_data_in[31]` differs from `req_q`.
- On acceptance, `req_q` is loaded with the new REQ value and the command (OP, PAY) is latched.

Opcodes:
- 0 NOP: no action; also clears ERR.
- 1 SETA: `addr` <= PAY[ADDR_W-1:0]; beat counter <= 0.
- 2 PUSH: `wbuf` <= {`wbuf`[DATA_W-17:0], PAY}, shifting left by 16. The beat counter increments, saturating at DATA_W/16.
- 3 WRITE: only if halted, pulse `mem_we` with `mem_addr`=`addr` and `mem_wdata`=`wbuf`. Then `addr` <= `addr`+1, wrapping modulo 2^ADDR_W. The beat counter resets to 0.
- 4 READ: only if halted, pulse `mem_re` at `addr`. Capture `mem_rdata` into `rbuf`. Then `addr` <= `addr`+1 (wrapping) and `hsel` <= 0.
- 5 HSEL: `hsel` <= PAY[1:0], selecting 16-bit half `hsel` of `rbuf` (0 = least significant). An out-of-range value selects 0.
- 6 HALT: `core_rst_n` <= 0.
- 7 RUN: `core_rst_n` <= 1.

Error conditions:
- WRITE or READ while running: no memory strobe, `addr` unchanged, ERR set. The command is still acknowledged.
- WRITE with beat counter != DATA_W/16: the write is performed, and ERR is set (incomplete word).

`la1_data_out` fields:
- [31] ACK.
- [30] HALTED (=!`core_rst_n`).
- [29] ERR (sticky).
- [28:16] `addr` zero-extended.
- [15:0] `rbuf` half `hsel`.

FSM states:
- IDLE: go to EXEC on acceptance.
- EXEC: perform the op. READ (when allowed) goes to RDW; all other ops go to ACK.
- RDW: capture `mem_rdata` into `rbuf`; go to ACK.
- ACK: ACK <= `req_q`; go to IDLE.

When `active` is low:
- The FSM is forced to IDLE and strobes are 0.
- `req_q` follows `la1_data_in[31]`, so commands issued while inactive are dropped.
- `core_rst_n`, `addr`, `wbuf` and `rbuf` hold their values.

## Timing
Reset values:
- FSM IDLE; `req_q`=0; ACK=0; ERR=0.
- `addr`, `wbuf`, `rbuf`, `hsel` and beat counter all 0.
- `mem_we`=`mem_re`=0; `busy`=0.
- `core_rst_n`=!BOOT_HALTED.
- The host must hold REQ=0 across reset.

Latency (acceptance is the clock edge at the end of cycle N):
- Cycle N+1: EXEC; `mem_we`/`mem_re` are high during this cycle, driven from registers.
- Non-read commands: ACK flips at the edge ending N+2.
- READ: `mem_rdata` is sampled at the end of N+2, and ACK flips at the end of N+3.
- `la1_data_out`[15:0] is valid when ACK flips.

Handshake and boundaries:
- REQ toggles during `busy` are not sampled until IDLE. Two toggles during one busy period cancel each other, and no command is seen.
- `addr` wraps from 2^ADDR_W-1 to 0 on WRITE and READ.
- HALT or RUN takes effect at the end of N+1. `core_rst_n` is registered and glitch-free.
- Asserting `rst_n` mid-command aborts it immediately. No partial strobe is allowed beyond the reset edge.

## Structure
- Package `la_prog_pkg`:
  - opcode localparams `OP_NOP`..`OP_RUN`;
  - FSM state enum {IDLE, EXEC, RDW, ACK};
  - field-position constants for the command and status words.
- Single module, no sub-modules. The toggle detector is inline.

## Test plan
1. Reset with BOOT_HALTED=1 → `core_rst_n`=0, `la1_data_out`=0x4000_0000, `busy`=0.
2. SETA 0x005, PUSH 0xDEAD, PUSH 0xBEEF, WRITE → one `mem_we` pulse with addr 5 and data 0xDEADBEEF; ACK flips 2 cycles after acceptance; `la1_data_out`[28:16]=6, ERR=0.
3. SETA 5, READ with memory model returning 0xDEADBEEF → `la1_data_out`[15:0]=0xBEEF, ACK 3 cycles after acceptance; HSEL 1 → 0xDEAD.
4. RUN then WRITE → no `mem_we`, ERR=1, `addr` unchanged; NOP → ERR=0.
5. SETA 0x3FF (ADDR_W=10), PUSH×2, WRITE → write at 0x3FF, then `addr`=0; WRITE after one PUSH → ERR=1.
6. Toggle REQ with `active`=0, raise `active` → no command executes; assert `rst_n` during RDW → `busy`=0 and no ACK flip.
